// File: rtl/fb_arbiter_if.sv
// fb_arbiter_if: CPU pixel-write port and single-port framebuffer RAM port of fb_arbiter
//   cpu_req/cpu_addr/cpu_wdata -> write request held until cpu_ack
//   cpu_ack                    <- one-cycle write-complete pulse
//   ram_addr/ram_we/ram_wdata  <- RAM control, ram_rdata -> RAM read data (1-cycle latency)
//   slave modport: arbiter side; master modport: CPU/RAM environment side
interface fb_arbiter_if #(
    parameter int ADDR_W = 19
);
    logic              cpu_req;
    logic [ADDR_W-1:0] cpu_addr;
    logic [2:0]        cpu_wdata;
    logic              cpu_ack;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [2:0]        ram_wdata;
    logic [2:0]        ram_rdata;
    modport master (
        output cpu_req, cpu_addr, cpu_wdata, ram_rdata,
        input  cpu_ack, ram_addr, ram_we, ram_wdata
    );
    modport slave (
        input  cpu_req, cpu_addr, cpu_wdata, ram_rdata,
        output cpu_ack, ram_addr, ram_we, ram_wdata
    );
endinterface

// File: rtl/fb_arbiter.sv
// fb_arbiter: shares the 3-bit framebuffer RAM between display scan-out fetches and CPU writes
//   clk_100mhz_buf : system clock        rst        : async active-low reset
//   bus            : CPU write port + RAM port (fb_arbiter_if.slave)
//   vsync_start    : frame start pulse   fifo_full  : pixel FIFO full flag
//   pix_data/pix_valid : FIFO write side frame_done : last pixel of frame delivered
//   addr_err/sync_err  : sticky out-of-range CPU address / early vsync flags
module fb_arbiter #(
    parameter int H_PIX  = 640,
    parameter int V_PIX  = 480,
    parameter int ADDR_W = 19
) (
    input  logic          clk_100mhz_buf,
    input  logic          rst,
    fb_arbiter_if.slave   bus,
    input  logic          vsync_start,
    input  logic          fifo_full,
    output logic [2:0]    pix_data,
    output logic          pix_valid,
    output logic          frame_done,
    output logic          addr_err,
    output logic          sync_err
);
    localparam int FRAME = H_PIX * V_PIX;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FRAME - 1);

    typedef enum logic {WAIT_VS, SCAN} state_t;

    state_t            state, state_d;
    logic [ADDR_W-1:0] fetch_addr, fetch_addr_d;
    // rd1: fetch address on the RAM bus; rd2: read data available on ram_rdata
    logic              rd1, rd2, last1, last2;
    logic              can_fetch, final_go, early, fetch_go, cpu_go, in_range;

    always_comb begin
        can_fetch    = state == SCAN && !fifo_full && !(rd1 || rd2);
        final_go     = can_fetch && fetch_addr == LAST;
        // A vsync that coincides with the final grant is a normal new frame, not a resync
        early        = state == SCAN && vsync_start && !final_go;
        fetch_go     = can_fetch && !early;
        // Never ack back-to-back so a held request is not written twice
        cpu_go       = bus.cpu_req && !fetch_go && !bus.cpu_ack;
        in_range     = {1'b0, bus.cpu_addr} < (ADDR_W + 1)'(FRAME);
        state_d      = vsync_start ? SCAN : final_go ? WAIT_VS : state;
        fetch_addr_d = (vsync_start || final_go) ? '0 : fetch_go ? fetch_addr + 1'b1 : fetch_addr;
    end

    always_ff @(posedge clk_100mhz_buf or negedge rst) begin
        if (!rst) begin
            state         <= WAIT_VS;
            fetch_addr    <= '0;
            rd1           <= 1'b0;
            rd2           <= 1'b0;
            last1         <= 1'b0;
            last2         <= 1'b0;
            pix_data      <= '0;
            pix_valid     <= 1'b0;
            frame_done    <= 1'b0;
            addr_err      <= 1'b0;
            sync_err      <= 1'b0;
            bus.cpu_ack   <= 1'b0;
            bus.ram_addr  <= '0;
            bus.ram_we    <= 1'b0;
            bus.ram_wdata <= '0;
        end else begin
            state       <= state_d;
            fetch_addr  <= fetch_addr_d;
            rd1         <= fetch_go;
            rd2         <= rd1 && !early;
            last1       <= final_go;
            last2       <= last1 && !early;
            pix_valid   <= rd2 && !early;
            frame_done  <= rd2 && last2 && !early;
            if (rd2 && !early)
                pix_data <= bus.ram_rdata;
            bus.cpu_ack <= cpu_go;
            bus.ram_we  <= cpu_go && in_range;
            if (fetch_go)
                bus.ram_addr <= fetch_addr;
            else if (cpu_go) begin
                bus.ram_addr  <= bus.cpu_addr;
                bus.ram_wdata <= bus.cpu_wdata;
            end
            addr_err    <= addr_err || (cpu_go && !in_range);
            sync_err    <= sync_err || early;
        end
    end
endmodule
